serial_subtractor6: RTL and testbench
=====================================

Name: serial_subtractor6

Overview:
- Bit-serial 6-bit subtractor computing a - b, one bit per clock, LSB first.
- Counterpart of the team's combinational ripple-carry adder. Reuses the same 1-bit cell style (a full subtractor in place of the full adder), iterated over time instead of replicated in space.
- Sits between a producer and a consumer on valid/ready handshakes.
- Result is 7 bits: difference plus borrow-out. The result is the 7-bit two's-complement value of a - b.

Parameters:
- WIDTH, 6, operand width; result is WIDTH+1 bits; iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- out_valid  output  1  diff holds a completed result
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH+1  {borrow_out, difference}; two's-complement a - b, range -63..+63
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, diff=0.
  - Operand shift registers, borrow and counter are all cleared.
  - Any operation in progress is aborted and its result discarded.
- FSM IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready: capture a and b into shift registers, set borrow=0, cnt=0, go to SHIFT.
  - out_ready is ignored.
- FSM SHIFT:
  - in_ready=0.
  - Each edge: the full_subtractor cell takes a_sh[0], b_sh[0] and borrow. It produces d = a^b^bin and bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the result register from the MSB side. a_sh and b_sh shift right. borrow <= bout. cnt increments.
  - When cnt reaches WIDTH-1, on that edge: load diff <= {bout, d, upper result bits} and go to DONE.
- FSM DONE:
  - out_valid=1; diff is held stable.
  - On an edge with out_ready=1, go to IDLE: out_valid=0, in_ready=1 from the next cycle.
  - out_ready low holds DONE indefinitely; no data is lost.
- Latency: the accept edge is E0; out_valid is high after edge E+WIDTH (6 cycles).
- Throughput: at most one operation per WIDTH+2 cycles. Accepting new input in the same cycle as the output handshake is not permitted.
- in_valid while busy is ignored; operands are not sampled.
- diff changes only on the SHIFT→DONE edge or at reset. It holds its last value in IDLE.
- Width rule: result = (a - b) mod 2^(WIDTH+1). diff[WIDTH] = 1 exactly when a < b.
- cnt is clog2(WIDTH) bits wide and never wraps: it clears on accept.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module, full_subtractor: ports diff, b_out, a, b, b_in, purely combinational, mirroring the full_adder cell.
- The top contains the FSM, shift registers, borrow flop and counter.

Test Plan:
- a=5, b=3 -> out_valid 6 cycles after accept, diff=7'b0000010.
- a=0, b=1 -> diff=7'h7F (-1); a=0, b=63 -> diff=7'h41 (-63); a=63, b=63 -> diff=7'h00.
- a=63, b=0 followed by out_ready held low 5 cycles -> out_valid stays high, diff=7'h3F is stable throughout, in_ready=0; release -> IDLE next cycle.
- in_valid pulsed with a=1, b=1 during SHIFT of a=10, b=4 -> ignored; diff=7'h06.
- rst_n asserted mid-SHIFT (cycle 3) -> all outputs at reset values immediately. A new op a=2, b=7 after release -> diff=7'h7B.
- Back-to-back random 500 ops with random out_ready -> every diff equals (a-b) mod 128, in order, none dropped or duplicated.

Source files
------------

// File: rtl/serial_subtractor6_pkg.sv
// Shared definitions for the bit-serial subtractor slice.
//   state_e : FSM state encoding (idle, shifting, result held)
//   Width   : default operand width
package serial_subtractor6_pkg;

  localparam int unsigned Width = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor6_if.sv
// Producer/consumer handshake bundle for serial_subtractor6.
//   in_valid/in_ready/a/b    : operand handshake (producer -> block)
//   out_valid/out_ready/diff : result handshake (block -> consumer)
//   busy                     : block is shifting or holding a result
// The block connects through the slave modport, the environment through master.
interface serial_subtractor6_if
  import serial_subtractor6_pkg::*;
#(
  parameter int unsigned WIDTH = Width
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, busy
  );

endinterface

// File: rtl/serial_subtractor6_full_subtractor.sv
// One-bit full subtractor cell, the borrow-chain counterpart of the full_adder cell.
//   a, b  : minuend and subtrahend bits
//   b_in  : borrow in from the less significant bit
//   diff  : difference bit
//   b_out : borrow out to the next bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor6.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through a
// single full_subtractor cell. Result is {borrow_out, difference}, i.e. the
// (WIDTH+1)-bit two's-complement value of a - b.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : operand/result handshakes plus busy (slave side)
module serial_subtractor6
  import serial_subtractor6_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor6_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Holds the low WIDTH-1 difference bits; the last bit and borrow go straight to diff.
  logic [WIDTH-2:0]  res_q, res_d;
  logic [WIDTH:0]    diff_q, diff_d;

  logic cell_diff;
  logic cell_bout;

  full_subtractor u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .b_in  (borrow_q),
    .diff  (cell_diff),
    .b_out (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    diff_d   = diff_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bout;
        res_d    = {cell_diff, res_q[WIDTH-2:1]};
        if (cnt_q == CntLast) begin
          // After WIDTH-1 shifts bit i of the result sits at res_q[i].
          diff_d  = {cell_bout, cell_diff, res_q};
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StShift) || (state_q == StDone);
  assign bus.diff      = diff_q;

endmodule

// File: tb/tb_serial_subtractor6.sv
module tb_serial_subtractor6;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  serial_subtractor6_if bus ();

  serial_subtractor6 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: (a - b) mod 128 with plain integer arithmetic.
  function automatic logic [6:0] model(input logic [5:0] x, input logic [5:0] y);
    int r;
    r = (int'(x) - int'(y) + 128) % 128;
    return 7'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed operation: optional in_valid noise during SHIFT, out_ready held
  // low for 'hold' cycles once the result is up.
  task automatic do_op(input logic [5:0] av, input logic [5:0] bv, input int hold,
                       input bit noise);
    logic [6:0] exp;
    int lat;
    exp = model(av, bv);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b0;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = noise;
    if (noise) begin
      bus.a = 6'd1;
      bus.b = 6'd1;
    end
    check("shift_busy", 32'(bus.busy), 32'd1);
    check("shift_in_ready", 32'(bus.in_ready), 32'd0);
    check("shift_out_valid", 32'(bus.out_valid), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'd6);
    check("diff", 32'(bus.diff), 32'(exp));
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_diff", 32'(bus.diff), 32'(exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_busy", 32'(bus.busy), 32'd0);
    check("idle_diff_held", 32'(bus.diff), 32'(exp));
  endtask

  logic [6:0] exp_q[$];
  logic [6:0] front;
  int n_acc;
  int n_done;
  int cycles;
  bit fired;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(6'd5, 6'd3, 0, 1'b0);
    check("5-3", 32'(bus.diff), 32'h02);
    do_op(6'd0, 6'd1, 0, 1'b0);
    check("0-1", 32'(bus.diff), 32'h7F);
    do_op(6'd0, 6'd63, 0, 1'b0);
    check("0-63", 32'(bus.diff), 32'h41);
    do_op(6'd63, 6'd63, 0, 1'b0);
    check("63-63", 32'(bus.diff), 32'h00);
    do_op(6'd63, 6'd0, 5, 1'b0);
    check("63-0", 32'(bus.diff), 32'h3F);
    do_op(6'd10, 6'd4, 0, 1'b1);
    check("10-4_noise", 32'(bus.diff), 32'h06);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 6'd20;
    bus.b        = 6'd9;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'd2, 6'd7, 0, 1'b0);
    check("2-7", 32'(bus.diff), 32'h7B);

    // Random back-to-back traffic with random consumer stalls.
    n_acc  = 0;
    n_done = 0;
    cycles = 0;
    fired  = 1'b0;
    while (n_done < 500 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (fired) begin
        bus.in_valid = 1'b0;
        fired        = 1'b0;
      end
      if (!bus.in_valid && n_acc < 500 && $urandom_range(0, 3) != 0) begin
        bus.a        = 6'($urandom);
        bus.b        = 6'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b));
        n_acc++;
        fired = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("rand_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          front = exp_q.pop_front();
          check("rand_diff", 32'(bus.diff), 32'(front));
        end
        n_done++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_in_time", 32'(cycles < 40000), 32'd1);
    check("rand_accepted", 32'(n_acc), 32'd500);
    check("rand_completed", 32'(n_done), 32'd500);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
